// File: rtl/axi4_lite_regbank_if.sv
// AXI4-Lite channel bundle shared by the register bank and its bus master.
// The s modport is the subordinate view, m the manager view.
interface axi4_lite_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport s (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );

  modport m (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );
endinterface

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite register bank: byte-strobed RW registers, RO status registers,
// independent write/read FSMs, SLVERR on out-of-range or RO writes.
module axi4_lite_regbank #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic clk,
  input  logic rst,
  axi4_lite_if.s axi,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0] reg_wr_pulse
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int IDX_W = ADDRESS_WIDTH - ADDR_LSB;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_VALID} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic              aw_held;
  logic              w_held;
  logic [IDX_W-1:0]  aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0] w_strb;

  logic [NUM_REGS-1:0]   w_sel;
  logic                  w_ok;
  logic [IDX_W-1:0]      ar_idx;
  logic                  r_hit;
  logic [DATA_WIDTH-1:0] r_val;

  logic unused;
  assign unused = ^{axi.awprot, axi.arprot,
                    axi.awaddr[ADDR_LSB-1:0],
                    axi.araddr[ADDR_LSB-1:0], status_i};

  assign axi.awready = (w_state == W_IDLE) && !aw_held;
  assign axi.wready  = (w_state == W_IDLE) && !w_held;
  assign axi.arready = (r_state == R_IDLE);

  assign ar_idx = axi.araddr[ADDRESS_WIDTH-1:ADDR_LSB];

  // Only an in-range RW register can be selected; RO and out-of-range leave w_sel empty
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      w_sel[i] = (aw_idx == IDX_W'(i)) && !RO_MASK[i];
    w_ok = |w_sel;
  end

  always_comb begin
    r_hit = 1'b0;
    r_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        r_hit = 1'b1;
        r_val = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] =
      RO_MASK[g] ? '0 : regs[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state      <= W_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      axi.bvalid   <= 1'b0;
      axi.bresp    <= 2'b00;
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VALUE;
    end else begin
      reg_wr_pulse <= '0;
      unique case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            w_state    <= W_RESP;
            axi.bvalid <= 1'b1;
            axi.bresp  <= w_ok ? 2'b00 : 2'b10;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (w_sel[i]) begin
                reg_wr_pulse[i] <= 1'b1;
                for (int b = 0; b < STRB_W; b++)
                  if (w_strb[b])
                    regs[i][8*b +: 8] <= w_data[8*b +: 8];
              end
            end
          end else begin
            if (axi.awvalid && !aw_held) begin
              aw_held <= 1'b1;
              aw_idx  <= axi.awaddr[ADDRESS_WIDTH-1:ADDR_LSB];
            end
            if (axi.wvalid && !w_held) begin
              w_held <= 1'b1;
              w_data <= axi.wdata;
              w_strb <= axi.wstrb;
            end
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            axi.bvalid <= 1'b0;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= R_IDLE;
      axi.rvalid <= 1'b0;
      axi.rdata  <= '0;
      axi.rresp  <= 2'b00;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (axi.arvalid) begin
            r_state    <= R_VALID;
            axi.rvalid <= 1'b1;
            axi.rdata  <= r_hit ? r_val : '0;
            axi.rresp  <= r_hit ? 2'b00 : 2'b10;
          end
        end
        R_VALID: begin
          if (axi.rready) begin
            axi.rvalid <= 1'b0;
            r_state    <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Directed bench for axi4_lite_regbank: 8 x 32-bit registers, reg 0 read-only.
// Expected values are hand-computed constants tracked in exp_q.
module tb_axi4_lite_regbank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [255:0] status_i;
  logic [255:0] reg_q;
  logic [7:0]   reg_wr_pulse;
  logic [255:0] exp_q;

  int errors = 0;
  int checks = 0;

  axi4_lite_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_regbank #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS(8),
    .RO_MASK(8'h01),
    .RESET_VALUE(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axi(axi),
    .status_i(status_i),
    .reg_q(reg_q),
    .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [7:0] pulse);
    logic awh, wh, done;
    axi.awaddr  = addr;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    for (int i = 0; i < 20 && (axi.awvalid || axi.wvalid); i++) begin
      awh = axi.awvalid && axi.awready;
      wh  = axi.wvalid && axi.wready;
      tick();
      if (awh) axi.awvalid = 1'b0;
      if (wh)  axi.wvalid = 1'b0;
    end
    chk("wr_handshake_timeout", {axi.awvalid, axi.wvalid}, 2'b00);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (axi.bvalid) done = 1'b1;
      else tick();
    end
    chk("bvalid_timeout", done, 1'b1);
    resp  = axi.bresp;
    pulse = reg_wr_pulse;
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic hs, done;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = axi.arready;
      tick();
    end
    chk("ar_timeout", hs, 1'b1);
    axi.arvalid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (axi.rvalid) done = 1'b1;
      else tick();
    end
    chk("rvalid_timeout", done, 1'b1);
    data = axi.rdata;
    resp = axi.rresp;
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic [31:0] data;

    axi.awvalid = 1'b0; axi.awaddr = '0; axi.awprot = '0;
    axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb  = '0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0; axi.araddr = '0; axi.arprot = '0;
    axi.rready  = 1'b0;
    status_i = {224'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1234_5678_9ABC,
                32'h0000_A5A5};
    exp_q = '0;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_awready", axi.awready, 1'b1);
    chk("rst_wready", axi.wready, 1'b1);
    chk("rst_arready", axi.arready, 1'b1);
    chk("rst_bvalid", axi.bvalid, 1'b0);
    chk("rst_rvalid", axi.rvalid, 1'b0);
    chk("rst_rdata", axi.rdata, 32'h0);
    chk("rst_reg_q", reg_q, exp_q);
    chk("rst_pulse", reg_wr_pulse, 8'h00);

    // reg 2 write, AW and W together
    axi.awaddr = 32'h8; axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    chk("t1_bvalid_early", axi.bvalid, 1'b0);
    tick();
    exp_q[2*32 +: 32] = 32'hDEADBEEF;
    chk("t1_bvalid", axi.bvalid, 1'b1);
    chk("t1_bresp", axi.bresp, 2'b00);
    chk("t1_pulse", reg_wr_pulse, 8'h04);
    chk("t1_reg_q", reg_q, exp_q);
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    chk("t1_bvalid_done", axi.bvalid, 1'b0);
    chk("t1_pulse_done", reg_wr_pulse, 8'h00);

    axi.araddr = 32'h8; axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0;
    chk("t1_rvalid", axi.rvalid, 1'b1);
    chk("t1_rdata", axi.rdata, 32'hDEADBEEF);
    chk("t1_rresp", axi.rresp, 2'b00);
    chk("t1_arready_busy", axi.arready, 1'b0);
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    chk("t1_rvalid_done", axi.rvalid, 1'b0);
    chk("t1_arready_back", axi.arready, 1'b1);

    // partial strobe on reg 1
    axi_write(32'h4, 32'h11223344, 4'hF, resp, pulse);
    chk("t2_resp_a", resp, 2'b00);
    chk("t2_pulse_a", pulse, 8'h02);
    axi_write(32'h4, 32'hAABBCCDD, 4'b0101, resp, pulse);
    chk("t2_resp_b", resp, 2'b00);
    exp_q[1*32 +: 32] = 32'h11BB33DD;
    axi_read(32'h4, data, resp);
    chk("t2_rdata", data, 32'h11BB33DD);
    chk("t2_rresp", resp, 2'b00);
    chk("t2_reg_q", reg_q, exp_q);

    // W three cycles before AW, bready held low 4 cycles
    axi.wdata = 32'h12345678; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    chk("t3_wready_low", axi.wready, 1'b0);
    chk("t3_awready_high", axi.awready, 1'b1);
    tick();
    tick();
    axi.awaddr = 32'hC; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    tick();
    exp_q[3*32 +: 32] = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      chk("t3_bvalid_hold", axi.bvalid, 1'b1);
      chk("t3_bresp_hold", axi.bresp, 2'b00);
      chk("t3_readies_low", {axi.awready, axi.wready}, 2'b00);
      tick();
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    chk("t3_bvalid_done", axi.bvalid, 1'b0);
    chk("t3_readies_back", {axi.awready, axi.wready}, 2'b11);
    chk("t3_reg_q", reg_q, exp_q);

    // read-only reg 0
    axi_write(32'h0, 32'hFFFFFFFF, 4'hF, resp, pulse);
    chk("t4_resp", resp, 2'b10);
    chk("t4_pulse", pulse, 8'h00);
    chk("t4_reg_q", reg_q, exp_q);
    axi_read(32'h0, data, resp);
    chk("t4_rdata", data, 32'h0000A5A5);
    chk("t4_rresp", resp, 2'b00);

    // out of range
    axi_write(32'h40, 32'h55AA55AA, 4'hF, resp, pulse);
    chk("t5_resp", resp, 2'b10);
    chk("t5_pulse", pulse, 8'h00);
    chk("t5_reg_q", reg_q, exp_q);
    axi_read(32'h40, data, resp);
    chk("t5_rdata", data, 32'h0);
    chk("t5_rresp", resp, 2'b10);

    // zero strobe to RW reg 2: OKAY, pulse, no change
    axi_write(32'h8, 32'h0BAD0BAD, 4'h0, resp, pulse);
    chk("t5z_resp", resp, 2'b00);
    chk("t5z_pulse", pulse, 8'h04);
    chk("t5z_reg_q", reg_q, exp_q);

    // reset with both responses pending
    axi.awaddr = 32'h10; axi.wdata = 32'h01020304; axi.wstrb = 4'hF;
    axi.araddr = 32'h8;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    tick();
    chk("t6_bvalid_pend", axi.bvalid, 1'b1);
    chk("t6_rvalid_pend", axi.rvalid, 1'b1);
    rst = 1'b1;
    #1;
    exp_q = '0;
    chk("t6_bvalid_rst", axi.bvalid, 1'b0);
    chk("t6_rvalid_rst", axi.rvalid, 1'b0);
    chk("t6_reg_q_rst", reg_q, exp_q);
    tick();
    rst = 1'b0;
    axi_write(32'h14, 32'hCAFEF00D, 4'hF, resp, pulse);
    exp_q[5*32 +: 32] = 32'hCAFEF00D;
    chk("t6_resp", resp, 2'b00);
    chk("t6_pulse", pulse, 8'h20);
    chk("t6_reg_q", reg_q, exp_q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
